// File: rtl/alu_rs_pkg.sv
// Shared defaults and op-class encodings for the ALU reservation station.
// Optional feature macro: RS_DISPATCH_BYPASS_EN (see alu_rs.sv).
package alu_rs_pkg;

    localparam int RS_DEPTH_DEF     = 8;
    localparam int OP_WIDTH_DEF     = 7;
    localparam int VAL_WIDTH_DEF    = 32;
    localparam int ROB_ID_WIDTH_DEF = 4;
    localparam int ADDR_WIDTH_DEF   = 32;

    // Op class lives in op_type[6:4]; funct3 in [3:1]; variant bit in [0].
    typedef enum logic [2:0] {
        OP_ARITH_R_TYPE = 3'd0,
        OP_ARITH_I_TYPE = 3'd1,
        OP_LUI_TYPE     = 3'd2,
        OP_AUIPC_TYPE   = 3'd3,
        OP_JAL_TYPE     = 3'd4,
        OP_JALR_TYPE    = 3'd5,
        OP_BRANCH_TYPE  = 3'd6
    } op_class_e;

endpackage

// File: rtl/alu_rs_pick_lowest.sv
// Priority picker: returns whether any bit of vec is set and the index of the lowest one.
module rs_pick_lowest #(
    parameter int N         = 8,
    parameter int IDX_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         vec,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle.
// Define RS_DISPATCH_BYPASS_EN to let a fully ready dispatch go straight to the ALU when nothing stored is ready.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH     = RS_DEPTH_DEF,
    parameter int OP_WIDTH     = OP_WIDTH_DEF,
    parameter int VAL_WIDTH    = VAL_WIDTH_DEF,
    parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    disp_valid,
    input  logic [OP_WIDTH-1:0]     disp_type,
    input  logic [VAL_WIDTH-1:0]    disp_vj,
    input  logic [VAL_WIDTH-1:0]    disp_vk,
    input  logic                    disp_qj_busy,
    input  logic [ROB_ID_WIDTH-1:0] disp_qj,
    input  logic                    disp_qk_busy,
    input  logic [ROB_ID_WIDTH-1:0] disp_qk,
    input  logic [ROB_ID_WIDTH-1:0] disp_entry,
    input  logic [ADDR_WIDTH-1:0]   disp_pc,
    output logic                    rs_full,
    output logic                    alu_exec,
    output logic [OP_WIDTH-1:0]     alu_type,
    output logic [VAL_WIDTH-1:0]    alu_val1,
    output logic [VAL_WIDTH-1:0]    alu_val2,
    output logic [ROB_ID_WIDTH-1:0] alu_entry,
    output logic [ADDR_WIDTH-1:0]   alu_pc,
    input  logic                    cdb_alu_rdy,
    input  logic [ROB_ID_WIDTH-1:0] cdb_alu_id,
    input  logic [VAL_WIDTH-1:0]    cdb_alu_val,
    input  logic                    cdb_lsb_rdy,
    input  logic [ROB_ID_WIDTH-1:0] cdb_lsb_id,
    input  logic [VAL_WIDTH-1:0]    cdb_lsb_val
);

    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH + 1);

    logic [RS_DEPTH-1:0]     busy, qj_busy, qk_busy;
    logic [OP_WIDTH-1:0]     e_type  [RS_DEPTH];
    logic [VAL_WIDTH-1:0]    e_vj    [RS_DEPTH];
    logic [VAL_WIDTH-1:0]    e_vk    [RS_DEPTH];
    logic [ROB_ID_WIDTH-1:0] e_qj    [RS_DEPTH];
    logic [ROB_ID_WIDTH-1:0] e_qk    [RS_DEPTH];
    logic [ROB_ID_WIDTH-1:0] e_entry [RS_DEPTH];
    logic [ADDR_WIDTH-1:0]   e_pc    [RS_DEPTH];
    logic [CW-1:0]           count;

    logic          free_found, ready_found;
    logic [IW-1:0] free_idx, ready_idx;
    logic          fj_busy, fk_busy;
    logic [VAL_WIDTH-1:0] fj_val, fk_val;
    logic          do_bypass, do_alloc;

    rs_pick_lowest #(.N(RS_DEPTH), .IDX_WIDTH(IW)) u_pick_free (
        .vec   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_pick_lowest #(.N(RS_DEPTH), .IDX_WIDTH(IW)) u_pick_ready (
        .vec   (busy & ~qj_busy & ~qk_busy),
        .found (ready_found),
        .idx   (ready_idx)
    );

    // Dispatch forwarding: ALU broadcast takes precedence over LSB on a shared tag.
    always_comb begin
        fj_busy = disp_qj_busy;
        fj_val  = disp_vj;
        fk_busy = disp_qk_busy;
        fk_val  = disp_vk;
        if (disp_qj_busy) begin
            if (cdb_alu_rdy && cdb_alu_id == disp_qj) begin
                fj_busy = 1'b0;
                fj_val  = cdb_alu_val;
            end else if (cdb_lsb_rdy && cdb_lsb_id == disp_qj) begin
                fj_busy = 1'b0;
                fj_val  = cdb_lsb_val;
            end
        end
        if (disp_qk_busy) begin
            if (cdb_alu_rdy && cdb_alu_id == disp_qk) begin
                fk_busy = 1'b0;
                fk_val  = cdb_alu_val;
            end else if (cdb_lsb_rdy && cdb_lsb_id == disp_qk) begin
                fk_busy = 1'b0;
                fk_val  = cdb_lsb_val;
            end
        end
    end

`ifdef RS_DISPATCH_BYPASS_EN
    assign do_bypass = disp_valid && !rs_full && !fj_busy && !fk_busy && !ready_found;
`else
    assign do_bypass = 1'b0;
`endif

    assign do_alloc = disp_valid && !rs_full && free_found && !do_bypass;
    assign rs_full  = (count == CW'(RS_DEPTH));

    // NOTE: entry payload is qualified by busy, so it is left out of reset; only control state is reset.
    always_ff @(posedge clk) begin
        if (rdy_in && !flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i] && qj_busy[i]) begin
                    if (cdb_alu_rdy && cdb_alu_id == e_qj[i]) begin
                        e_vj[i]    <= cdb_alu_val;
                        qj_busy[i] <= 1'b0;
                    end else if (cdb_lsb_rdy && cdb_lsb_id == e_qj[i]) begin
                        e_vj[i]    <= cdb_lsb_val;
                        qj_busy[i] <= 1'b0;
                    end
                end
                if (busy[i] && qk_busy[i]) begin
                    if (cdb_alu_rdy && cdb_alu_id == e_qk[i]) begin
                        e_vk[i]    <= cdb_alu_val;
                        qk_busy[i] <= 1'b0;
                    end else if (cdb_lsb_rdy && cdb_lsb_id == e_qk[i]) begin
                        e_vk[i]    <= cdb_lsb_val;
                        qk_busy[i] <= 1'b0;
                    end
                end
            end
            if (do_alloc) begin
                e_type[free_idx]  <= disp_type;
                e_vj[free_idx]    <= fj_val;
                e_vk[free_idx]    <= fk_val;
                qj_busy[free_idx] <= fj_busy;
                qk_busy[free_idx] <= fk_busy;
                e_qj[free_idx]    <= disp_qj;
                e_qk[free_idx]    <= disp_qk;
                e_entry[free_idx] <= disp_entry;
                e_pc[free_idx]    <= disp_pc;
            end
        end
    end

    // NOTE: non-blocking assignments throughout so every read sees the state from the start of the cycle.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in || flush) begin
            busy      <= '0;
            count     <= '0;
            alu_exec  <= 1'b0;
            alu_type  <= '0;
            alu_val1  <= '0;
            alu_val2  <= '0;
            alu_entry <= '0;
            alu_pc    <= '0;
        end else if (rdy_in) begin
            if (ready_found) busy[ready_idx] <= 1'b0;
            if (do_alloc)    busy[free_idx]  <= 1'b1;
            count <= count + CW'(do_alloc) - CW'(ready_found);

            if (ready_found) begin
                alu_exec  <= 1'b1;
                alu_type  <= e_type[ready_idx];
                alu_val1  <= e_vj[ready_idx];
                alu_val2  <= e_vk[ready_idx];
                alu_entry <= e_entry[ready_idx];
                alu_pc    <= e_pc[ready_idx];
            end else if (do_bypass) begin
                alu_exec  <= 1'b1;
                alu_type  <= disp_type;
                alu_val1  <= fj_val;
                alu_val2  <= fk_val;
                alu_entry <= disp_entry;
                alu_pc    <= disp_pc;
            end else begin
                alu_exec  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios then random traffic against a slot-level reference model.
module tb_alu_rs;

`ifdef RS_DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        disp_valid;
    logic [6:0]  disp_type;
    logic [31:0] disp_vj, disp_vk, disp_pc;
    logic        disp_qj_busy, disp_qk_busy;
    logic [3:0]  disp_qj, disp_qk, disp_entry;
    logic        rs_full, alu_exec;
    logic [6:0]  alu_type;
    logic [31:0] alu_val1, alu_val2, alu_pc;
    logic [3:0]  alu_entry;
    logic        cdb_alu_rdy, cdb_lsb_rdy;
    logic [3:0]  cdb_alu_id, cdb_lsb_id;
    logic [31:0] cdb_alu_val, cdb_lsb_val;

    int total = 0;
    int bad   = 0;

    alu_rs dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk),
        .disp_entry(disp_entry), .disp_pc(disp_pc), .rs_full(rs_full),
        .alu_exec(alu_exec), .alu_type(alu_type), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_entry(alu_entry), .alu_pc(alu_pc),
        .cdb_alu_rdy(cdb_alu_rdy), .cdb_alu_id(cdb_alu_id), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_rdy(cdb_lsb_rdy), .cdb_lsb_id(cdb_lsb_id), .cdb_lsb_val(cdb_lsb_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [6:0]  typ;
        logic [31:0] vj, vk, pc;
        bit          jb, kb;
        logic [3:0]  qj, qk, ent;
    } slot_t;

    slot_t       m [D];
    bit          m_exec;
    logic [6:0]  m_type;
    logic [31:0] m_v1, m_v2, m_pc;
    logic [3:0]  m_ent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m[i].busy = 1'b0;
        m_exec = 1'b0; m_type = '0; m_v1 = '0; m_v2 = '0; m_ent = '0; m_pc = '0;
    endtask

    // An operand pending on tag q becomes ready if a valid CDB carries q; ALU broadcast wins.
    task automatic resolve(input bit pend, input logic [3:0] q, input logic [31:0] v,
                           output bit b, output logic [31:0] o);
        b = pend; o = v;
        if (pend) begin
            if (cdb_alu_rdy && cdb_alu_id == q)      begin b = 1'b0; o = cdb_alu_val; end
            else if (cdb_lsb_rdy && cdb_lsb_id == q) begin b = 1'b0; o = cdb_lsb_val; end
        end
    endtask

    task automatic model_step();
        int iss = -1, fr = -1;
        bit full = 1'b1, acc, byp, jb, kb;
        logic [31:0] jv, kv;
        if (flush) begin model_reset(); return; end
        if (!rdy_in) return;
        for (int i = 0; i < D; i++) begin
            if (!m[i].busy) begin full = 1'b0; if (fr < 0) fr = i; end
            if (iss < 0 && m[i].busy && !m[i].jb && !m[i].kb) iss = i;
        end
        resolve(disp_qj_busy, disp_qj, disp_vj, jb, jv);
        resolve(disp_qk_busy, disp_qk, disp_vk, kb, kv);
        acc = disp_valid && !full;
        byp = BYP && acc && !jb && !kb && iss < 0;
        if (iss >= 0) begin
            m_exec = 1'b1; m_type = m[iss].typ; m_v1 = m[iss].vj; m_v2 = m[iss].vk;
            m_ent = m[iss].ent; m_pc = m[iss].pc;
        end else if (byp) begin
            m_exec = 1'b1; m_type = disp_type; m_v1 = jv; m_v2 = kv; m_ent = disp_entry; m_pc = disp_pc;
        end else begin
            m_exec = 1'b0;
        end
        for (int i = 0; i < D; i++) begin
            if (m[i].busy) begin
                resolve(m[i].jb, m[i].qj, m[i].vj, m[i].jb, m[i].vj);
                resolve(m[i].kb, m[i].qk, m[i].vk, m[i].kb, m[i].vk);
            end
        end
        if (iss >= 0) m[iss].busy = 1'b0;
        if (acc && !byp)
            m[fr] = '{busy: 1'b1, typ: disp_type, vj: jv, vk: kv, pc: disp_pc,
                      jb: jb, kb: kb, qj: disp_qj, qk: disp_qk, ent: disp_entry};
    endtask

    task automatic compare();
        int n = 0;
        for (int i = 0; i < D; i++) if (m[i].busy) n++;
        check("rs_full",   rs_full,   (n == D));
        check("alu_exec",  alu_exec,  m_exec);
        check("alu_type",  alu_type,  m_type);
        check("alu_val1",  alu_val1,  m_v1);
        check("alu_val2",  alu_val2,  m_v2);
        check("alu_entry", alu_entry, m_ent);
        check("alu_pc",    alu_pc,    m_pc);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_type = '0; disp_vj = '0; disp_vk = '0; disp_pc = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0; disp_entry = '0;
        cdb_alu_rdy = 1'b0; cdb_alu_id = '0; cdb_alu_val = '0;
        cdb_lsb_rdy = 1'b0; cdb_lsb_id = '0; cdb_lsb_val = '0;
    endtask

    task automatic dispatch(input logic [6:0] t, input logic [31:0] vj, input logic [31:0] vk,
                            input bit jb, input logic [3:0] qj, input bit kb, input logic [3:0] qk,
                            input logic [3:0] ent, input logic [31:0] pc);
        disp_valid = 1'b1; disp_type = t; disp_vj = vj; disp_vk = vk;
        disp_qj_busy = jb; disp_qj = qj; disp_qk_busy = kb; disp_qk = qk;
        disp_entry = ent; disp_pc = pc;
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_exec", alu_exec, 1'b0);
        check("reset_full", rs_full, 1'b0);
        rst_in = 1'b0;
        step();

        // addi, both operands ready
        dispatch(7'h10, 32'd5, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h40);
        step();
        idle();
        step();
        check("t2_val1", alu_val1, 32'd5);
        check("t2_val2", alu_val2, 32'd3);
        check("t2_entry", alu_entry, 4'd2);
        check("t2_pc", alu_pc, 32'h40);
        step();

        // vj pending on tag 4, woken by ALU CDB two cycles later
        dispatch(7'h12, 32'd0, 32'd1, 1'b1, 4'd4, 1'b0, 4'd0, 4'd5, 32'h44);
        step();
        idle();
        step();
        cdb_alu_rdy = 1'b1; cdb_alu_id = 4'd4; cdb_alu_val = 32'h10;
        step();
        idle();
        step();
        check("t3_exec", alu_exec, 1'b1);
        check("t3_val1", alu_val1, 32'h10);
        check("t3_val2", alu_val2, 32'd1);

        // vk pending on tag 7, forwarded from LSB CDB at dispatch
        dispatch(7'h14, 32'd2, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd6, 32'h48);
        cdb_lsb_rdy = 1'b1; cdb_lsb_id = 4'd7; cdb_lsb_val = 32'd9;
        step();
        idle();
        step();
        check("t4_val2", alu_val2, 32'd9);
        step();

        // reset asserted mid-run with a ready op about to issue
        dispatch(7'h16, 32'h77, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h50);
        step();
        idle();
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        check("t1_exec", alu_exec, 1'b0);
        check("t1_full", rs_full, 1'b0);
        check("t1_val1", alu_val1, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        repeat (3) step();

        // fill all slots with blocked ops, then wake slots 1 and 3
        for (int i = 0; i < D; i++) begin
            dispatch(7'h60, 32'd0, 32'(100 + i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i), 32'(32'h100 + 4 * i));
            step();
        end
        check("t5_full", rs_full, 1'b1);
        dispatch(7'h10, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15, 32'h200);
        step();
        check("t5_full_ignored", rs_full, 1'b1);
        idle();
        cdb_alu_rdy = 1'b1; cdb_alu_id = 4'd9;  cdb_alu_val = 32'hA1;
        cdb_lsb_rdy = 1'b1; cdb_lsb_id = 4'd11; cdb_lsb_val = 32'hB3;
        step();
        idle();
        step();
        check("t5_first_entry", alu_entry, 4'd1);
        check("t5_first_val1", alu_val1, 32'hA1);
        step();
        check("t5_second_entry", alu_entry, 4'd3);
        check("t5_second_val1", alu_val1, 32'hB3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_flush_full", rs_full, 1'b0);
        check("t5_flush_exec", alu_exec, 1'b0);
        step();

        // freeze with a ready entry held
        dispatch(7'h18, 32'h66, 32'h99, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'h60);
        step();
        idle();
        rdy_in = 1'b0;
        cdb_alu_rdy = 1'b1; cdb_alu_id = 4'd3; cdb_alu_val = 32'h1234;
        repeat (3) step();
        idle();
        step();
        check("t6_val1", alu_val1, 32'h66);
        check("t6_entry", alu_entry, 4'd3);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 59) == 0);
            disp_valid   = ($urandom_range(0, 2) != 0);
            disp_type    = 7'($urandom);
            disp_vj      = $urandom;
            disp_vk      = $urandom;
            disp_qj_busy = ($urandom_range(0, 2) == 0);
            disp_qk_busy = ($urandom_range(0, 2) == 0);
            disp_qj      = 4'($urandom_range(0, 15));
            disp_qk      = 4'($urandom_range(0, 15));
            disp_entry   = 4'($urandom_range(0, 15));
            disp_pc      = $urandom;
            cdb_alu_rdy  = ($urandom_range(0, 1) == 0);
            cdb_alu_id   = 4'($urandom_range(0, 15));
            cdb_alu_val  = $urandom;
            cdb_lsb_rdy  = ($urandom_range(0, 1) == 0);
            cdb_lsb_id   = 4'($urandom_range(0, 15));
            cdb_lsb_val  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
